// File: rtl/addr_map.sv
// rtl/addr_map.sv - programmable SNES-to-ROM address window map with unlock hold FSM
module addr_map #(
  parameter int          NWIN        = 4,
  parameter int          UNLOCK_HOLD = 16,
  parameter logic [23:0] DEF_MASK    = 24'h3FFFFF
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [23:0]     SNES_ADDR,
  input  logic            ADDR_VALID,
  input  logic            CFG_WE,
  input  logic [2:0]      CFG_IDX,
  input  logic [1:0]      CFG_SEL,
  input  logic [23:0]     CFG_DATA,
  input  logic            CFG_COMMIT,
  input  logic            MAP_UNLOCK_REQ,
  output logic [23:0]     ROM_ADDR,
  output logic            ROM_HIT,
  output logic            IS_WRITABLE,
  output logic [NWIN-1:0] WIN_HIT,
  output logic            OUT_VALID,
  output logic            map_unlock
);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    HOLD     = 2'd2
  } unlock_state_e;

  // ctrl field bit positions
  localparam int C_EN    = 0;
  localparam int C_WR    = 1;
  localparam int C_PATCH = 2;

  // Shadow table (MCU-visible) and active table (used by lookups)
  logic [23:0] sh_base_q  [NWIN];
  logic [23:0] sh_base_d  [NWIN];
  logic [23:0] sh_mask_q  [NWIN];
  logic [23:0] sh_mask_d  [NWIN];
  logic [23:0] sh_tgt_q   [NWIN];
  logic [23:0] sh_tgt_d   [NWIN];
  logic [2:0]  sh_ctrl_q  [NWIN];
  logic [2:0]  sh_ctrl_d  [NWIN];
  logic [23:0] act_base_q [NWIN];
  logic [23:0] act_base_d [NWIN];
  logic [23:0] act_mask_q [NWIN];
  logic [23:0] act_mask_d [NWIN];
  logic [23:0] act_tgt_q  [NWIN];
  logic [23:0] act_tgt_d  [NWIN];
  logic [2:0]  act_ctrl_q [NWIN];
  logic [2:0]  act_ctrl_d [NWIN];

  // Stage 1: sampled address, raw hits and the fields of the lowest-index hit.
  // Capturing the winner's fields here keeps a lookup consistent with the
  // table it was matched against even if a commit lands before stage 2.
  logic [23:0]     s1_addr_q,  s1_addr_d;
  logic            s1_valid_q, s1_valid_d;
  logic [NWIN-1:0] s1_hit_q,   s1_hit_d;
  logic [23:0]     s1_mask_q,  s1_mask_d;
  logic [23:0]     s1_tgt_q,   s1_tgt_d;
  logic            s1_wr_q,    s1_wr_d;
  logic            s1_patch_q, s1_patch_d;

  // Stage 2: registered outputs
  logic [23:0]     rom_addr_q,  rom_addr_d;
  logic            rom_hit_q,   rom_hit_d;
  logic            is_wr_q,     is_wr_d;
  logic [NWIN-1:0] win_hit_q,   win_hit_d;
  logic            out_valid_q, out_valid_d;

  // Unlock FSM
  unlock_state_e state_q, state_d;
  logic [7:0]    cnt_q,   cnt_d;
  logic          map_unlock_q, map_unlock_d;

  // Shadow writes, then commit copies the post-write shadow into the active table
  always_comb begin
    sh_base_d  = sh_base_q;
    sh_mask_d  = sh_mask_q;
    sh_tgt_d   = sh_tgt_q;
    sh_ctrl_d  = sh_ctrl_q;
    act_base_d = act_base_q;
    act_mask_d = act_mask_q;
    act_tgt_d  = act_tgt_q;
    act_ctrl_d = act_ctrl_q;
    for (int i = 0; i < NWIN; i++) begin
      if (CFG_WE && (CFG_IDX == 3'(i))) begin
        case (CFG_SEL)
          2'd0:    sh_base_d[i] = CFG_DATA;
          2'd1:    sh_mask_d[i] = CFG_DATA;
          2'd2:    sh_tgt_d[i]  = CFG_DATA;
          default: sh_ctrl_d[i] = CFG_DATA[2:0];
        endcase
      end
    end
    if (CFG_COMMIT) begin
      act_base_d = sh_base_d;
      act_mask_d = sh_mask_d;
      act_tgt_d  = sh_tgt_d;
      act_ctrl_d = sh_ctrl_d;
    end
  end

  // Stage 1: per-window match against the active table and winner field select
  always_comb begin
    s1_addr_d  = SNES_ADDR;
    s1_valid_d = ADDR_VALID;
    s1_hit_d   = '0;
    s1_mask_d  = '0;
    s1_tgt_d   = '0;
    s1_wr_d    = 1'b0;
    s1_patch_d = 1'b0;
    for (int i = 0; i < NWIN; i++) begin
      s1_hit_d[i] = act_ctrl_q[i][C_EN] &&
                    (((SNES_ADDR ^ act_base_q[i]) & act_mask_q[i]) == 24'd0);
    end
    // Walk downwards so the lowest-index hit is the one left selected
    for (int i = NWIN - 1; i >= 0; i--) begin
      if (s1_hit_d[i]) begin
        s1_mask_d  = act_mask_q[i];
        s1_tgt_d   = act_tgt_q[i];
        s1_wr_d    = act_ctrl_q[i][C_WR];
        s1_patch_d = act_ctrl_q[i][C_PATCH];
      end
    end
  end

  // Stage 2: priority one-hot and address translation
  always_comb begin
    out_valid_d = s1_valid_q;
    win_hit_d   = s1_hit_q & (~s1_hit_q + NWIN'(1));
    rom_hit_d   = |s1_hit_q;
    if (rom_hit_d) begin
      rom_addr_d = (s1_tgt_q & s1_mask_q) | (s1_addr_q & ~s1_mask_q);
      is_wr_d    = s1_wr_q | (s1_patch_q & map_unlock_q);
    end else begin
      rom_addr_d = s1_addr_q & DEF_MASK;
      is_wr_d    = 1'b0;
    end
  end

  // Unlock FSM next state and hold counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOCKED: begin
        if (MAP_UNLOCK_REQ) state_d = UNLOCKED;
      end
      UNLOCKED: begin
        if (!MAP_UNLOCK_REQ) begin
          state_d = HOLD;
          cnt_d   = 8'(UNLOCK_HOLD - 1);
        end
      end
      HOLD: begin
        if (MAP_UNLOCK_REQ) begin
          state_d = UNLOCKED;
        end else if (cnt_q == 8'd0) begin
          state_d = LOCKED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = LOCKED;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Unlock FSM output: map_unlock follows the state being entered
  always_comb begin
    map_unlock_d = (state_d != LOCKED);
  end

  // All state registers; reset takes priority over config and lookups
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NWIN; i++) begin
        sh_base_q[i]  <= '0;
        sh_mask_q[i]  <= '0;
        sh_tgt_q[i]   <= '0;
        sh_ctrl_q[i]  <= '0;
        act_base_q[i] <= '0;
        act_mask_q[i] <= '0;
        act_tgt_q[i]  <= '0;
        act_ctrl_q[i] <= '0;
      end
      s1_addr_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_hit_q     <= '0;
      s1_mask_q    <= '0;
      s1_tgt_q     <= '0;
      s1_wr_q      <= 1'b0;
      s1_patch_q   <= 1'b0;
      rom_addr_q   <= '0;
      rom_hit_q    <= 1'b0;
      is_wr_q      <= 1'b0;
      win_hit_q    <= '0;
      out_valid_q  <= 1'b0;
      state_q      <= LOCKED;
      cnt_q        <= 8'd0;
      map_unlock_q <= 1'b0;
    end else begin
      sh_base_q    <= sh_base_d;
      sh_mask_q    <= sh_mask_d;
      sh_tgt_q     <= sh_tgt_d;
      sh_ctrl_q    <= sh_ctrl_d;
      act_base_q   <= act_base_d;
      act_mask_q   <= act_mask_d;
      act_tgt_q    <= act_tgt_d;
      act_ctrl_q   <= act_ctrl_d;
      s1_addr_q    <= s1_addr_d;
      s1_valid_q   <= s1_valid_d;
      s1_hit_q     <= s1_hit_d;
      s1_mask_q    <= s1_mask_d;
      s1_tgt_q     <= s1_tgt_d;
      s1_wr_q      <= s1_wr_d;
      s1_patch_q   <= s1_patch_d;
      rom_addr_q   <= rom_addr_d;
      rom_hit_q    <= rom_hit_d;
      is_wr_q      <= is_wr_d;
      win_hit_q    <= win_hit_d;
      out_valid_q  <= out_valid_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      map_unlock_q <= map_unlock_d;
    end
  end

  assign ROM_ADDR    = rom_addr_q;
  assign ROM_HIT     = rom_hit_q;
  assign IS_WRITABLE = is_wr_q;
  assign WIN_HIT     = win_hit_q;
  assign OUT_VALID   = out_valid_q;
  assign map_unlock  = map_unlock_q;

endmodule

// File: tb/tb_addr_map.sv
// tb/tb_addr_map.sv - directed self-checking bench for addr_map
module tb_addr_map;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] snes_addr;
  logic        addr_valid;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [1:0]  cfg_sel;
  logic [23:0] cfg_data;
  logic        cfg_commit;
  logic        unlock_req;
  logic [23:0] rom_addr;
  logic        rom_hit;
  logic        is_writable;
  logic [3:0]  win_hit;
  logic        out_valid;
  logic        map_unlock;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addr_map #(.NWIN(4), .UNLOCK_HOLD(4), .DEF_MASK(24'h3FFFFF)) dut (
    .CLK           (clk),
    .RST_N         (rst_n),
    .SNES_ADDR     (snes_addr),
    .ADDR_VALID    (addr_valid),
    .CFG_WE        (cfg_we),
    .CFG_IDX       (cfg_idx),
    .CFG_SEL       (cfg_sel),
    .CFG_DATA      (cfg_data),
    .CFG_COMMIT    (cfg_commit),
    .MAP_UNLOCK_REQ(unlock_req),
    .ROM_ADDR      (rom_addr),
    .ROM_HIT       (rom_hit),
    .IS_WRITABLE   (is_writable),
    .WIN_HIT       (win_hit),
    .OUT_VALID     (out_valid),
    .map_unlock    (map_unlock)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [1:0] sel, input logic [23:0] data,
                     input logic commit);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_data = data; cfg_commit = commit;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  task automatic lookup(input logic [23:0] a);
    snes_addr = a; addr_valid = 1'b1;
    step();
    addr_valid = 1'b0;
    step();
  endtask

  task automatic chk_out(input string tag, input logic [23:0] a, input logic h,
                         input logic w, input logic [3:0] wh);
    chk({tag, "_valid"}, 24'(out_valid), 24'd1);
    chk({tag, "_addr"},  rom_addr, a);
    chk({tag, "_hit"},   24'(rom_hit), 24'(h));
    chk({tag, "_wr"},    24'(is_writable), 24'(w));
    chk({tag, "_win"},   24'(win_hit), 24'(wh));
  endtask

  initial begin
    rst_n = 1'b0; snes_addr = '0; addr_valid = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_sel = '0; cfg_data = '0; cfg_commit = 1'b0; unlock_req = 1'b0;
    step(); step();
    chk("rst_valid", 24'(out_valid), 24'd0);
    chk("rst_hit",   24'(rom_hit), 24'd0);
    chk("rst_addr",  rom_addr, 24'd0);
    chk("rst_win",   24'(win_hit), 24'd0);
    chk("rst_wr",    24'(is_writable), 24'd0);
    chk("rst_unl",   24'(map_unlock), 24'd0);
    rst_n = 1'b1;

    // Miss path and 2-cycle latency
    snes_addr = 24'h808000; addr_valid = 1'b1;
    step();
    addr_valid = 1'b0;
    chk("lat_s1_valid", 24'(out_valid), 24'd0);
    step();
    chk_out("miss", 24'h008000, 1'b0, 1'b0, 4'b0000);
    step();
    chk("valid_drop", 24'(out_valid), 24'd0);

    // Basic hit; shadow alone must not change lookups
    cfg(3'd0, 2'd0, 24'h700000, 1'b0);
    cfg(3'd0, 2'd1, 24'hF80000, 1'b0);
    cfg(3'd0, 2'd2, 24'hE00000, 1'b0);
    cfg(3'd0, 2'd3, 24'h000003, 1'b0);
    lookup(24'h713456);
    chk_out("precommit", 24'h313456, 1'b0, 1'b0, 4'b0000);
    commit();
    lookup(24'h713456);
    chk_out("basic", 24'hE13456, 1'b1, 1'b1, 4'b0001);

    // Out-of-range index write is ignored
    cfg(3'd5, 2'd3, 24'h000001, 1'b1);
    lookup(24'h713456);
    chk_out("idx_oob", 24'hE13456, 1'b1, 1'b1, 4'b0001);

    // Priority: windows 0 and 2 overlap
    cfg(3'd0, 2'd0, 24'h400000, 1'b0);
    cfg(3'd0, 2'd1, 24'hFF0000, 1'b0);
    cfg(3'd0, 2'd2, 24'hA00000, 1'b0);
    cfg(3'd0, 2'd3, 24'h000001, 1'b0);
    cfg(3'd2, 2'd0, 24'h400000, 1'b0);
    cfg(3'd2, 2'd1, 24'hF00000, 1'b0);
    cfg(3'd2, 2'd2, 24'h100000, 1'b0);
    cfg(3'd2, 2'd3, 24'h000001, 1'b1);
    lookup(24'h401234);
    chk_out("prio", 24'hA01234, 1'b1, 1'b0, 4'b0001);
    lookup(24'h4A0000);
    chk_out("win2", 24'h1A0000, 1'b1, 1'b0, 4'b0100);

    // Commit timing: commit-cycle lookup sees old table, next cycle sees new
    cfg(3'd2, 2'd2, 24'h200000, 1'b0);
    lookup(24'h4A0000);
    chk_out("sh_only", 24'h1A0000, 1'b1, 1'b0, 4'b0100);
    snes_addr = 24'h4A0000; addr_valid = 1'b1; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step();
    addr_valid = 1'b0;
    chk_out("cm_old", 24'h1A0000, 1'b1, 1'b0, 4'b0100);
    step();
    chk_out("cm_new", 24'h2A0000, 1'b1, 1'b0, 4'b0100);

    // Write coinciding with commit is included
    cfg(3'd2, 2'd2, 24'h300000, 1'b1);
    lookup(24'h4A0000);
    chk_out("we_cm", 24'h3A0000, 1'b1, 1'b0, 4'b0100);

    // Patch window while locked
    cfg(3'd1, 2'd0, 24'hC00000, 1'b0);
    cfg(3'd1, 2'd1, 24'hFF0000, 1'b0);
    cfg(3'd1, 2'd2, 24'h500000, 1'b0);
    cfg(3'd1, 2'd3, 24'h000005, 1'b1);
    lookup(24'hC01234);
    chk_out("patch_lk", 24'h501234, 1'b1, 1'b0, 4'b0010);

    // Unlock pulse: high for 5 cycles with UNLOCK_HOLD=4
    unlock_req = 1'b1;
    step();
    unlock_req = 1'b0;
    chk("unl_0", 24'(map_unlock), 24'd1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("unl_%0d", i), 24'(map_unlock), 24'd1);
    end
    step();
    chk("unl_5", 24'(map_unlock), 24'd0);

    // Reassert during HOLD
    unlock_req = 1'b1; step(); unlock_req = 1'b0;
    step(); step();
    unlock_req = 1'b1; step(); unlock_req = 1'b0;
    chk("re_d", 24'(map_unlock), 24'd1);
    step(); step(); step();
    chk("re_g", 24'(map_unlock), 24'd1);
    step();
    chk("re_h", 24'(map_unlock), 24'd1);
    step();
    chk("re_i", 24'(map_unlock), 24'd0);

    // Patch window while unlocked
    unlock_req = 1'b1;
    step();
    lookup(24'hC01234);
    chk_out("patch_ul", 24'h501234, 1'b1, 1'b1, 4'b0010);

    // Reset mid-stream
    snes_addr = 24'hC01234; addr_valid = 1'b1;
    step(); step();
    rst_n = 1'b0; unlock_req = 1'b0;
    step();
    chk("mrst_valid", 24'(out_valid), 24'd0);
    chk("mrst_unl",   24'(map_unlock), 24'd0);
    chk("mrst_hit",   24'(rom_hit), 24'd0);
    rst_n = 1'b1; addr_valid = 1'b0;
    step();
    chk("mrst_flush", 24'(out_valid), 24'd0);
    lookup(24'hC01234);
    chk_out("mrst_w1", 24'h001234, 1'b0, 1'b0, 4'b0000);
    lookup(24'h713456);
    chk_out("mrst_w0", 24'h313456, 1'b0, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
